beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Step scheduler for the drum sequencer. It generates the running step index (0–7) at a programmable tempo and runs a play/pause/stop state machine. It stores an editable 8-step on/off pattern per drum track and issues one-cycle trigger pulses to the sample players at each step boundary. Its `beat` output drives the LED step display directly: value 8 means stopped and falls into the display's all-off default.

## Interface
Parameters:
- `NUM_TRACKS`, default 4: number of drum tracks, each with an 8-step pattern.
- `STEP_BASE`, default 3125000: base cycle count; step period = `STEP_BASE * (16 - tempo)` cycles.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: play from stop, or resume from pause.
- `pause`  in  1  one-cycle pulse: freeze playback.
- `stop`  in  1  one-cycle pulse: halt and rewind.
- `tempo`  in  4  0 = slowest, 15 = fastest.
- `edit_track`  in  clog2(NUM_TRACKS)  track selected for editing and readback.
- `edit_step`  in  3  step selected for editing.
- `edit_toggle`  in  1  one-cycle pulse: invert pattern bit [edit_track][edit_step].
- `beat`  out  4  current step 0–7; 8 when stopped.
- `step_tick`  out  1  one-cycle pulse on every step entry.
- `trig`  out  NUM_TRACKS  one-cycle pulse per track whose pattern bit is set at the entered step.
- `row_out`  out  8  combinational readback of the pattern row for `edit_track`.

## Operation
- States: STOPPED, PLAYING, PAUSED.
- Command priority when pulses coincide: stop > pause > start.
- STOPPED:
  - `start` → PLAYING; enters step 0, counter cleared.
  - `pause` is ignored.
- PLAYING:
  - Counter increments every cycle.
  - When counter ≥ period−1: counter clears, `beat` = (beat+1) mod 8 (7 wraps to 0), and the step is entered.
  - `pause` → PAUSED. `stop` → STOPPED.
- PAUSED:
  - Counter and `beat` hold; no ticks or trigs.
  - `start` → PLAYING, continuing from the held counter with no trigger on resume.
  - `stop` → STOPPED.
- Any transition to STOPPED: `beat` = 8, counter = 0.
- Step entry (from start or advance): `step_tick` = 1 and `trig[t]` = pattern[t][new step], registered, in the same cycle `beat` shows the new step.
- Period arithmetic:
  - Period is computed every cycle from the current `tempo`: `STEP_BASE*(16-tempo)`, range STEP_BASE×1 to STEP_BASE×16.
  - The counter is wide enough for `STEP_BASE*16`.
  - A tempo change takes effect immediately. If the counter is already ≥ the new period−1, the step advances on the next cycle.
- Pattern edits:
  - `edit_toggle` is accepted in every state.
  - The bit flips at the clock edge, so `row_out` shows the new value the following cycle.
  - If a toggle and a step entry target the same bit in the same cycle, `trig` uses the pre-toggle value.
- Reset: all pattern bits are cleared.

## Timing
- Reset values: state STOPPED, `beat` = 8, counter 0, `step_tick` 0, `trig` all 0, pattern all 0.
- Reset overrides every command in the same cycle, including mid-step.
- `start` sampled at edge N → `beat` = 0 and the first `step_tick`/`trig` visible after edge N. The next step enters exactly one period later.
- Steady PLAYING: `step_tick` is high exactly 1 of every period cycles.
- `pause` at edge N: `beat` is frozen after N, and no tick can occur after N.
- Remaining cycles after resume = period − held counter − 1, so total play time per step is preserved across a pause.
- `trig` and `step_tick` are never high outside PLAYING.

## Test plan
- Reset, then STEP_BASE=2, tempo=15 (period 2), `start` → `beat` runs 0,0,1,1,…,7,7,0; `step_tick` on every 2nd cycle; wrap 7→0 with a tick.
- Pattern track0 = 8'b0101_0101 (steps 0,2,4,6), track1 = step 3 only, tempo=14 (period 4) → `trig[0]` pulses at beats 0,2,4,6, `trig[1]` at beat 3, each 1 cycle wide.
- Tempo=0 (period 32), `pause` at counter 10, hold 50 cycles, `start` → no tick during pause; next step enters 21 cycles after resume.
- `stop` mid-step, then `start` → `beat` = 8 and no trig while stopped; restart enters step 0 with trig from pattern[*][0].
- Toggle the bit for the upcoming step in the same cycle as its entry → `trig` reflects the old value; `row_out` shows the flipped bit the next cycle.
- `start`+`stop` in the same cycle while PLAYING → STOPPED (`beat` = 8). `reset` asserted mid-play → all outputs at reset values next cycle.

Source files
------------

// File: rtl/beat_sequencer.sv
// Drum step scheduler: play/pause/stop FSM, tempo-driven step counter, 8-step pattern per track.
// Step entry appears as registered beat/step_tick/trig one cycle after the deciding edge; no backpressure.
module beat_sequencer #(
  parameter int NUM_TRACKS = 4,
  parameter int STEP_BASE  = 3125000,
  localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int CW = $clog2(STEP_BASE * 16 + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  input  logic [3:0]            tempo,
  input  logic [TW-1:0]         edit_track,
  input  logic [2:0]            edit_step,
  input  logic                  edit_toggle,
  output logic [3:0]            beat,
  output logic                  step_tick,
  output logic [NUM_TRACKS-1:0] trig,
  output logic [7:0]            row_out
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_PLAYING,
    ST_PAUSED
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         period;
  logic [CW-1:0]         period_m1;
  logic [4:0]            mult;
  logic                  step_due;
  logic [2:0]            entry_step;
  logic [NUM_TRACKS-1:0] entry_bits;
  logic [7:0]            pattern [NUM_TRACKS];

  // Period follows tempo combinationally so a tempo change applies on the very next edge.
  assign mult      = 5'd16 - {1'b0, tempo};
  assign period    = CW'(STEP_BASE) * CW'(mult);
  assign period_m1 = period - CW'(1);
  assign step_due  = (cnt >= period_m1);

  // From STOPPED the entered step is 0; while playing beat is 0..7 so the 3-bit add wraps 7->0.
  assign entry_step = (state == ST_STOPPED) ? 3'd0 : (beat[2:0] + 3'd1);

  always_comb begin
    entry_bits = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      entry_bits[t] = pattern[t][entry_step];
    end
  end

  assign row_out = pattern[edit_track];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOPPED;
      beat      <= 4'd8;
      cnt       <= '0;
      step_tick <= 1'b0;
      trig      <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        pattern[t] <= '0;
      end
    end else begin
      step_tick <= 1'b0;
      trig      <= '0;

      // trig above samples the pre-edge pattern, so a coincident toggle never affects it.
      if (edit_toggle) begin
        pattern[edit_track][edit_step] <= ~pattern[edit_track][edit_step];
      end

      case (state)
        ST_STOPPED: begin
          if (start && !stop) begin
            state     <= ST_PLAYING;
            beat      <= 4'd0;
            cnt       <= '0;
            step_tick <= 1'b1;
            trig      <= entry_bits;
          end
        end

        ST_PLAYING: begin
          if (stop) begin
            state <= ST_STOPPED;
            beat  <= 4'd8;
            cnt   <= '0;
          end else if (pause) begin
            state <= ST_PAUSED;
          end else if (step_due) begin
            cnt       <= '0;
            beat      <= {1'b0, entry_step};
            step_tick <= 1'b1;
            trig      <= entry_bits;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_PAUSED: begin
          if (stop) begin
            state <= ST_STOPPED;
            beat  <= 4'd8;
            cnt   <= '0;
          end else if (start && !pause) begin
            // The resume cycle counts as play time; an already-due count advances one cycle later.
            state <= ST_PLAYING;
            if (!step_due) begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        default: begin
          state <= ST_STOPPED;
          beat  <= 4'd8;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a step-timing model built from elapsed-cycle bookkeeping.
module tb_beat_sequencer;

  localparam int NT = 4;
  localparam int SB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          stop = 1'b0;
  logic [3:0]    tempo = 4'd15;
  logic [1:0]    edit_track = 2'd0;
  logic [2:0]    edit_step = 3'd0;
  logic          edit_toggle = 1'b0;
  logic [3:0]    beat;
  logic          step_tick;
  logic [NT-1:0] trig;
  logic [7:0]    row_out;

  beat_sequencer #(.NUM_TRACKS(NT), .STEP_BASE(SB)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .tempo(tempo), .edit_track(edit_track), .edit_step(edit_step),
    .edit_toggle(edit_toggle), .beat(beat), .step_tick(step_tick),
    .trig(trig), .row_out(row_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: mode 0=stopped 1=playing 2=paused; m_el counts cycles already spent in the current step.
  int       m_mode = 0;
  int       m_beat = 8;
  int       m_el = 0;
  int       m_per;
  bit       m_tick = 1'b0;
  bit [3:0] m_trig = '0;
  bit [7:0] m_pat [NT];
  bit       model_ok = 1'b0;

  task automatic m_enter(input int nb);
    m_beat = nb;
    m_el   = 0;
    m_tick = 1'b1;
    for (int t = 0; t < NT; t++) m_trig[t] = m_pat[t][nb];
  endtask

  always @(posedge clk) begin
    m_per  = SB * (16 - int'(tempo));
    m_tick = 1'b0;
    m_trig = '0;
    if (reset) begin
      m_mode = 0; m_beat = 8; m_el = 0; model_ok = 1'b1;
      for (int t = 0; t < NT; t++) m_pat[t] = '0;
    end else begin
      if (m_mode == 0) begin
        if (start && !stop) begin m_mode = 1; m_enter(0); end
      end else if (stop) begin
        m_mode = 0; m_beat = 8; m_el = 0;
      end else if (m_mode == 1) begin
        if (pause) m_mode = 2;
        else if (m_el + 1 >= m_per) m_enter((m_beat + 1) % 8);
        else m_el++;
      end else if (start && !pause) begin
        m_mode = 1;
        if (m_el + 1 < m_per) m_el++;
      end
      if (edit_toggle) m_pat[edit_track][edit_step] = ~m_pat[edit_track][edit_step];
    end
  end

  always @(negedge clk) begin
    if (model_ok && !reset) begin
      chk("beat", 32'(beat), 32'(m_beat));
      chk("step_tick", 32'(step_tick), 32'(m_tick));
      chk("trig", 32'(trig), 32'(m_trig));
      chk("row_out", 32'(row_out), 32'(m_pat[edit_track]));
    end
  end

  task automatic pulse_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; step(); stop  = 1'b0; endtask
  task automatic toggle(input int t, input int s);
    edit_track = 2'(t); edit_step = 3'(s); edit_toggle = 1'b1; step(); edit_toggle = 1'b0;
  endtask

  int n0, n1, bad, k, b1;

  initial begin
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_beat", 32'(beat), 32'd8);
    chk("reset_tick_trig", {27'd0, step_tick, trig}, 32'd0);
    chk("reset_row", 32'(row_out), 32'd0);

    // Period 2: beat 0,0,1,1,...,7,7,0 with a tick on every entry.
    tempo = 4'd15;
    pulse_start();
    for (int i = 0; i <= 16; i++) begin
      chk("p2_beat", 32'(beat), 32'((i / 2) % 8));
      chk("p2_tick", 32'(step_tick), 32'(i % 2 == 0));
      step();
    end
    pulse_stop();
    chk("stop_beat", 32'(beat), 32'd8);

    for (int s = 0; s < 8; s += 2) toggle(0, s);
    toggle(1, 3);
    edit_track = 2'd0; #1;
    chk("row_t0", 32'(row_out), 32'h55);
    edit_track = 2'd1; #1;
    chk("row_t1", 32'(row_out), 32'h08);
    edit_track = 2'd0;

    // Period 4 lap: trig[0] at even beats, trig[1] at beat 3 only.
    tempo = 4'd14;
    pulse_start();
    n0 = 0; n1 = 0; bad = 0; b1 = -1;
    for (int i = 0; i < 32; i++) begin
      if (trig[0]) begin n0++; if (beat[0] || !step_tick) bad++; end
      if (trig[1]) begin n1++; b1 = int'(beat); end
      step();
    end
    chk("trig0_count", 32'(n0), 32'd4);
    chk("trig0_even", 32'(bad), 32'd0);
    chk("trig1_count", 32'(n1), 32'd1);
    chk("trig1_beat", 32'(b1), 32'd3);

    // Period 32: pause at counter 10, hold 50, resume; next entry 21 cycles later.
    pulse_stop();
    tempo = 4'd0;
    pulse_start();
    for (int i = 0; i < 10; i++) step();
    pause = 1'b1; step(); pause = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (step_tick || trig != 0 || beat != 4'd0) bad++;
      step();
    end
    chk("pause_hold", 32'(bad), 32'd0);
    pulse_start();
    chk("resume_no_tick", {27'd0, step_tick, trig}, 32'd0);
    k = 0;
    while (!step_tick && k < 64) begin step(); k++; end
    chk("resume_gap", 32'(k), 32'd21);
    chk("resume_beat", 32'(beat), 32'd1);

    // Stop mid-step, stay stopped, restart at step 0.
    for (int i = 0; i < 5; i++) step();
    pulse_stop();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (beat != 4'd8 || step_tick || trig != 0) bad++;
      step();
    end
    chk("stopped_quiet", 32'(bad), 32'd0);
    pulse_start();
    chk("restart_beat", 32'(beat), 32'd0);
    chk("restart_trig", 32'(trig), 32'b0001);

    // Toggle track0 step1 on the same edge that enters step 1.
    pulse_stop();
    tempo = 4'd15;
    pulse_start();
    step();
    toggle(0, 1);
    chk("coinc_beat", 32'(beat), 32'd1);
    chk("coinc_trig0_old", 32'(trig[0]), 32'd0);
    chk("coinc_row_new", 32'(row_out), 32'h57);

    // start+stop together while playing stops.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_beat", 32'(beat), 32'd8);

    // Reset mid-play.
    pulse_start();
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_mid_beat", 32'(beat), 32'd8);
    chk("rst_mid_tick_trig", {27'd0, step_tick, trig}, 32'd0);
    chk("rst_mid_row", 32'(row_out), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      start = (r < 5);
      pause = (r >= 5 && r < 8);
      stop  = (r >= 8 && r < 10);
      reset = ($urandom_range(0, 599) == 0);
      edit_toggle = ($urandom_range(0, 9) == 0);
      edit_track  = 2'($urandom_range(0, NT - 1));
      edit_step   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) tempo = 4'($urandom_range(8, 15));
      step();
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0; reset = 1'b0; edit_toggle = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
